// File: rtl/puf_auth_verifier.sv
// puf_auth_verifier
// Challenge-side controller for the ring-oscillator PUF. Requests evaluations
// over an enable/valid handshake, enrolls a golden response by per-bit
// majority vote over NUM_SAMPLES evaluations, and authenticates a later
// evaluation by Hamming distance against that golden value.

module puf_auth_verifier #(
  parameter int RESP_W      = 4,
  parameter int NUM_SAMPLES = 5,
  parameter int HD_THRESH   = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode,
  output logic                         puf_enable,
  input  logic [RESP_W-1:0]            puf_resp,
  input  logic                         puf_valid,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         enrolled,
  output logic [RESP_W-1:0]            golden,
  output logic [$clog2(RESP_W+1)-1:0]  hd,
  output logic                         timeout_err,
  output logic                         not_enrolled_err
);

  localparam int CW   = $clog2(NUM_SAMPLES + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int HD_W = $clog2(RESP_W + 1);

  localparam logic [CW-1:0]   NS_C     = CW'(NUM_SAMPLES);
  localparam logic [CW-1:0]   HALF_C   = CW'(NUM_SAMPLES / 2);
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [HD_W-1:0] HD_THR_C = HD_W'(HD_THRESH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACCUM,
    S_EVAL
  } state_t;

  state_t              state_q;
  logic                mode_q;        // 0 = enroll, 1 = authenticate
  logic                abort_q;       // request timed out
  logic                noenr_q;       // authentication asked with nothing enrolled
  logic [RESP_W-1:0]   resp_q;        // last captured PUF response
  logic [CW-1:0]       samp_q;        // enrollment samples taken
  logic [TW-1:0]       tcnt_q;        // cycles spent waiting in the current request
  logic [CW-1:0]       ones_q [RESP_W];

  logic                puf_enable_q;
  logic                done_q;
  logic                pass_q;
  logic                enrolled_q;
  logic [RESP_W-1:0]   golden_q;
  logic [HD_W-1:0]     hd_q;
  logic                timeout_err_q;
  logic                not_enrolled_err_q;

  logic [RESP_W-1:0]   diff;
  logic [HD_W-1:0]     hd_calc;
  logic [RESP_W-1:0]   gold_calc;
  logic [CW-1:0]       samp_inc;

  // Hamming distance of the captured response, majority-vote golden, next sample count.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // logic so that no path leaves it unassigned and infers a latch.
    hd_calc   = '0;
    gold_calc = '0;
    diff      = resp_q ^ golden_q;
    samp_inc  = samp_q + CW'(1);
    for (int b = 0; b < RESP_W; b++) begin
      hd_calc      = hd_calc + HD_W'(diff[b]);
      gold_calc[b] = (ones_q[b] > HALF_C);
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= S_IDLE;
      mode_q             <= 1'b0;
      abort_q            <= 1'b0;
      noenr_q            <= 1'b0;
      resp_q             <= '0;
      samp_q             <= '0;
      tcnt_q             <= '0;
      // NOTE: the per-bit ones counters are a small register array, not a RAM,
      // so resetting them is cheap and keeps every counter at a known zero.
      for (int b = 0; b < RESP_W; b++) begin
        ones_q[b] <= '0;
      end
      puf_enable_q       <= 1'b0;
      done_q             <= 1'b0;
      pass_q             <= 1'b0;
      enrolled_q         <= 1'b0;
      golden_q           <= '0;
      hd_q               <= '0;
      timeout_err_q      <= 1'b0;
      not_enrolled_err_q <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so that every
      // right-hand side reads the value from before this clock edge.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pass_q             <= 1'b0;
            timeout_err_q      <= 1'b0;
            not_enrolled_err_q <= 1'b0;
            mode_q             <= mode;
            abort_q            <= 1'b0;
            samp_q             <= '0;
            tcnt_q             <= '0;
            for (int b = 0; b < RESP_W; b++) begin
              ones_q[b] <= '0;
            end
            if (mode && !enrolled_q) begin
              noenr_q <= 1'b1;
              state_q <= S_EVAL;
            end else begin
              noenr_q      <= 1'b0;
              puf_enable_q <= 1'b1;
              state_q      <= S_REQ;
            end
          end
        end

        S_REQ: begin
          // A response arriving on the last allowed cycle still counts.
          if (puf_valid) begin
            resp_q       <= puf_resp;
            puf_enable_q <= 1'b0;
            state_q      <= S_ACCUM;
          end else if (tcnt_q == TO_LAST) begin
            abort_q      <= 1'b1;
            puf_enable_q <= 1'b0;
            state_q      <= S_EVAL;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end

        S_ACCUM: begin
          if (!mode_q) begin
            for (int b = 0; b < RESP_W; b++) begin
              ones_q[b] <= ones_q[b] + CW'(resp_q[b]);
            end
            samp_q <= samp_inc;
            if (samp_inc < NS_C) begin
              tcnt_q       <= '0;
              puf_enable_q <= 1'b1;
              state_q      <= S_REQ;
            end else begin
              state_q <= S_EVAL;
            end
          end else begin
            state_q <= S_EVAL;
          end
        end

        S_EVAL: begin
          state_q <= S_IDLE;
          done_q  <= 1'b1;
          if (noenr_q) begin
            not_enrolled_err_q <= 1'b1;
            pass_q             <= 1'b0;
          end else if (abort_q) begin
            // Golden, enrolled and hd keep their previous values on abort.
            timeout_err_q <= 1'b1;
            pass_q        <= 1'b0;
          end else if (mode_q) begin
            hd_q   <= hd_calc;
            pass_q <= (hd_calc <= HD_THR_C);
          end else begin
            golden_q      <= gold_calc;
            enrolled_q    <= 1'b1;
            timeout_err_q <= 1'b0;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign puf_enable       = puf_enable_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign enrolled         = enrolled_q;
  assign golden           = golden_q;
  assign hd               = hd_q;
  assign timeout_err      = timeout_err_q;
  assign not_enrolled_err = not_enrolled_err_q;

endmodule

// File: tb/tb_puf_auth_verifier.sv
// Testbench for puf_auth_verifier: directed table, reset sequences and
// randomized operations checked against a behavioural model.

module tb_puf_auth_verifier;

  localparam int RW = 4;
  localparam int NS = 3;
  localparam int HT = 1;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic       puf_enable;
  logic [3:0] puf_resp;
  logic       puf_valid;
  logic       busy;
  logic       done;
  logic       pass;
  logic       enrolled;
  logic [3:0] golden;
  logic [2:0] hd;
  logic       timeout_err;
  logic       not_enrolled_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  puf_auth_verifier #(
    .RESP_W(RW), .NUM_SAMPLES(NS), .HD_THRESH(HT), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .puf_enable(puf_enable), .puf_resp(puf_resp), .puf_valid(puf_valid),
    .busy(busy), .done(done), .pass(pass), .enrolled(enrolled),
    .golden(golden), .hd(hd), .timeout_err(timeout_err),
    .not_enrolled_err(not_enrolled_err)
  );

  // Observed / expected outcome of one operation.
  typedef struct {
    int golden;
    int enrolled;
    int hd;
    int pass;
    int te;
    int nee;
    int pulses;   // number of puf_enable pulses
    int lat;      // negedges after the start edge until done is seen
    int max_hi;   // longest puf_enable high run
  } res_t;

  // Directed vector: inputs and expected outcome.
  typedef struct {
    bit          mode;
    logic [11:0] r;     // response for request 0 in [3:0], 1 in [7:4], 2 in [11:8]
    int          dly;   // puf_valid on this high cycle of each request (>TO: never)
    res_t        exp;
  } vec_t;

  // Reference model state.
  logic [3:0] m_golden;
  bit         m_enrolled;
  int         m_hd;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t zero_res();
    res_t z;
    z.golden = 0; z.enrolled = 0; z.hd = 0; z.pass = 0; z.te = 0; z.nee = 0;
    z.pulses = 0; z.lat = 0; z.max_hi = 0;
    return z;
  endfunction

  function automatic vec_t mk(input bit m, input logic [11:0] r, input int dly,
                              input int g, input int en, input int h, input int p,
                              input int te, input int nee, input int pul,
                              input int lat, input int mh);
    vec_t v;
    v.mode = m; v.r = r; v.dly = dly;
    v.exp.golden = g; v.exp.enrolled = en; v.exp.hd = h; v.exp.pass = p;
    v.exp.te = te; v.exp.nee = nee; v.exp.pulses = pul; v.exp.lat = lat;
    v.exp.max_hi = mh;
    return v;
  endfunction

  // Behavioural model: outcome of one operation from the rules alone.
  function automatic res_t model(input bit m, input logic [11:0] r, input int dly);
    res_t e;
    int   n_req;
    int   d;
    int   ones;
    e = zero_res();
    if (m && !m_enrolled) begin
      e.nee = 1;
      e.lat = 2;
    end else if (dly > TO) begin
      e.te     = 1;
      e.pulses = 1;
      e.max_hi = TO;
      e.lat    = TO + 2;
    end else begin
      n_req    = m ? 1 : NS;
      e.pulses = n_req;
      e.max_hi = dly;
      e.lat    = (n_req - 1) * (dly + 1) + dly + 3;
      if (m) begin
        d = 0;
        for (int b = 0; b < RW; b++) if (r[b] != m_golden[b]) d++;
        m_hd   = d;
        e.pass = (d <= HT) ? 1 : 0;
      end else begin
        for (int b = 0; b < RW; b++) begin
          ones = 0;
          for (int s = 0; s < NS; s++) ones += int'(r[s*4+b]);
          m_golden[b] = (2 * ones > NS);
        end
        m_enrolled = 1'b1;
      end
    end
    e.golden   = int'(m_golden);
    e.enrolled = int'(m_enrolled);
    e.hd       = m_hd;
    return e;
  endfunction

  task automatic compare_res(input string tag, input res_t a, input res_t e);
    check($sformatf("%s golden", tag),   a.golden,   e.golden);
    check($sformatf("%s enrolled", tag), a.enrolled, e.enrolled);
    check($sformatf("%s hd", tag),       a.hd,       e.hd);
    check($sformatf("%s pass", tag),     a.pass,     e.pass);
    check($sformatf("%s timeout_err", tag), a.te,    e.te);
    check($sformatf("%s not_enrolled_err", tag), a.nee, e.nee);
    check($sformatf("%s enable_pulses", tag), a.pulses, e.pulses);
    check($sformatf("%s done_latency", tag),  a.lat,    e.lat);
    check($sformatf("%s enable_high_max", tag), a.max_hi, e.max_hi);
  endtask

  task automatic check_reset(input string tag);
    check($sformatf("%s puf_enable", tag), int'(puf_enable), 0);
    check($sformatf("%s busy", tag),       int'(busy), 0);
    check($sformatf("%s done", tag),       int'(done), 0);
    check($sformatf("%s pass", tag),       int'(pass), 0);
    check($sformatf("%s enrolled", tag),   int'(enrolled), 0);
    check($sformatf("%s timeout_err", tag), int'(timeout_err), 0);
    check($sformatf("%s not_enrolled_err", tag), int'(not_enrolled_err), 0);
    check($sformatf("%s golden", tag),     int'(golden), 0);
    check($sformatf("%s hd", tag),         int'(hd), 0);
  endtask

  // Issue one operation and play the PUF; noise adds busy-time starts, mode
  // toggling and stray puf_valid strobes outside requests.
  task automatic run_op(input bit m, input logic [11:0] r, input int dly,
                        input bit noise, output res_t o);
    int hi;
    int idx;
    bit prev_en;
    bit got;
    o       = zero_res();
    o.lat   = -1;
    hi      = 0;
    idx     = 0;
    prev_en = 1'b0;
    got     = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = m; puf_valid = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= 300 && !got; n++) begin
      @(negedge clk);
      start = 1'b0; puf_valid = 1'b0;
      if (noise) mode = 1'($urandom);
      if (done) begin
        got   = 1'b1;
        o.lat = n;
        check("busy low with done", int'(busy), 0);
      end else begin
        if (puf_enable) begin
          if (!prev_en) begin
            o.pulses++;
            hi = 0;
          end
          hi++;
          if (hi > o.max_hi) o.max_hi = hi;
          if (hi == dly) begin
            puf_valid = 1'b1;
            puf_resp  = r[idx*4 +: 4];
            if (idx < 2) idx++;
          end
        end else if (noise) begin
          puf_valid = 1'($urandom);
          puf_resp  = 4'($urandom);
        end
        if (noise && busy) start = 1'($urandom);
      end
      prev_en = puf_enable;
    end
    o.golden   = int'(golden);
    o.enrolled = int'(enrolled);
    o.hd       = int'(hd);
    o.pass     = int'(pass);
    o.te       = int'(timeout_err);
    o.nee      = int'(not_enrolled_err);
    @(negedge clk);
    puf_valid = 1'b0; start = 1'b0;
    check("done single cycle", int'(done), 0);
  endtask

  vec_t vecs [8];
  res_t obs;
  res_t ex;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  pulses;
    bit  prev;
    bit  reached;
    bit  rm;
    logic [11:0] rr;
    int  rd;

    rst = 1'b1; start = 1'b0; mode = 1'b0; puf_valid = 1'b0; puf_resp = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("por");

    //            mode r        dly  gold  en hd p te nee pul lat mh
    vecs[0] = mk(1, 12'h000, 1,   4'h0, 0, 0, 0, 0, 1,  0,  2, 0);
    vecs[1] = mk(0, 12'h2BA, 1,   4'hA, 1, 0, 0, 0, 0,  3,  8, 1);
    vecs[2] = mk(1, 12'h00B, 3,   4'hA, 1, 1, 1, 0, 0,  1,  6, 3);
    vecs[3] = mk(1, 12'h003, 2,   4'hA, 1, 2, 0, 0, 0,  1,  5, 2);
    vecs[4] = mk(0, 12'h000, 99,  4'hA, 1, 2, 0, 1, 0,  1, 22, 20);
    vecs[5] = mk(1, 12'h00A, 20,  4'hA, 1, 0, 1, 0, 0,  1, 23, 20);
    vecs[6] = mk(0, 12'hC75, 20,  4'h5, 1, 0, 0, 0, 0,  3, 65, 20);
    vecs[7] = mk(1, 12'h00A, 5,   4'h5, 1, 4, 0, 0, 0,  1,  8, 5);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].mode, vecs[i].r, vecs[i].dly, 1'b0, obs);
      compare_res($sformatf("vec%0d", i), obs, vecs[i].exp);
    end

    // Reset while idle with results held.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset("idle_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("idle_rst_released");

    // Fresh enrollment, then reset during the third request with busy-time starts.
    m_golden = '0; m_enrolled = 1'b0; m_hd = 0;
    ex = model(1'b0, 12'h2BA, 2);
    run_op(1'b0, 12'h2BA, 2, 1'b0, obs);
    compare_res("pre_rst_enroll", obs, ex);

    @(negedge clk);
    start = 1'b1; mode = 1'b0;
    @(posedge clk);
    pulses = 0; prev = 1'b0; reached = 1'b0;
    for (int n = 0; n < 100 && !reached; n++) begin
      @(negedge clk);
      start = 1'b0; puf_valid = 1'b0;
      if (puf_enable && !prev) begin
        pulses++;
        if (pulses <= 2) begin
          puf_valid = 1'b1;
          puf_resp  = 4'h5;
        end else begin
          reached = 1'b1;
        end
      end
      if (busy && !reached) begin
        start = (n % 2 == 0);
        mode  = 1'($urandom);
      end
      prev = puf_enable;
    end
    check("mid_rst third request reached", int'(reached), 1);
    check("mid_rst enrolled before reset", int'(enrolled), 1);
    check("mid_rst golden before reset", int'(golden), 10);
    start = 1'b0; puf_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst puf_enable", int'(puf_enable), 0);
    check("mid_rst busy", int'(busy), 0);
    check("mid_rst enrolled", int'(enrolled), 0);
    check("mid_rst golden", int'(golden), 0);
    check("mid_rst done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized operations against the model.
    m_golden = '0; m_enrolled = 1'b0; m_hd = 0;
    for (int i = 0; i < 40; i++) begin
      rm = 1'($urandom);
      if (i == 1) rm = 1'b0;
      rr = 12'($urandom);
      rd = $urandom_range(1, 24);
      ex = model(rm, rr, rd);
      run_op(rm, rr, rd, 1'b1, obs);
      compare_res($sformatf("rnd%0d", i), obs, ex);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/puf_auth_verifier.md
# puf_auth_verifier

Challenge-side controller for the ring-oscillator PUF: requests PUF evaluations over an enable/valid handshake, builds an enrolled golden response by per-bit majority vote over several evaluations, and authenticates later evaluations by Hamming distance against that golden value. It sits between system control logic and the PUF core.

## Interface
- RESP_W, 4, PUF response width in bits (matches PUF NUM_RO/2)
- NUM_SAMPLES, 5, evaluations per enrollment; odd, ≥1
- HD_THRESH, 1, max Hamming distance accepted as pass
- TIMEOUT, 255, max cycles waiting for puf_valid per request; ≥1
- clk  in  1  clock
- rst  in  1  reset; rst is asynchronous, active-high; clock is clk
- start  in  1  begin operation; sampled only in IDLE
- mode  in  1  0 = enroll, 1 = authenticate; sampled with start
- puf_enable  out  1  request to PUF; held high until puf_valid
- puf_resp  in  RESP_W  PUF response; valid when puf_valid=1
- puf_valid  in  1  one-cycle response strobe from PUF
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- pass  out  1  authentication passed
- enrolled  out  1  golden register holds valid data
- golden  out  RESP_W  enrolled golden response
- hd  out  clog2(RESP_W+1)  Hamming distance of last authentication
- timeout_err  out  1  last operation aborted on timeout
- not_enrolled_err  out  1  last authentication requested with enrolled=0

## Operation
- States: IDLE, REQ, ACCUM, EVAL.
- IDLE: start=1 & mode=0 -> REQ; clear sample counter, per-bit ones counters, timeout counter. start=1 & mode=1 & enrolled=1 -> REQ. start=1 & mode=1 & enrolled=0 -> EVAL directly, no PUF request.
- REQ: puf_enable=1; timeout counter increments each cycle. puf_valid=1 -> capture puf_resp, ACCUM. Counter reaches TIMEOUT without puf_valid -> EVAL with abort flag. puf_valid in the same cycle as timeout: valid wins.
- ACCUM (one cycle, puf_enable=0): enroll adds each captured bit to its ones counter (width clog2(NUM_SAMPLES+1)), increments sample count; count < NUM_SAMPLES -> REQ (timeout counter cleared), else EVAL. Authenticate -> EVAL.
- EVAL (one cycle) -> IDLE; on exit edge register results, done<=1:
  - enroll success: golden[b] = ones[b] > NUM_SAMPLES/2; enrolled=1; timeout_err=0.
  - authenticate: hd = popcount(resp ^ golden); pass = hd ≤ HD_THRESH.
  - abort: timeout_err=1, pass=0; golden, enrolled unchanged; hd unchanged.
  - not enrolled: not_enrolled_err=1, pass=0.
- Each operation clears pass, timeout_err, not_enrolled_err at start acceptance; results hold until next start.
- start ignored while busy; mode changes while busy ignored.
- puf_valid outside REQ ignored.
- Re-enrollment overwrites golden only on success.

## Timing
- Reset: puf_enable, busy, done, pass, enrolled, timeout_err, not_enrolled_err = 0; golden, hd = 0; state IDLE; all counters 0.
- All outputs registered except busy (decode of state).
- start sampled at edge k -> puf_enable high from cycle k+1.
- puf_valid sampled at edge m -> puf_enable low from m; at least one low cycle (ACCUM) between consecutive requests; next request high from m+1.
- Authentication latency: valid at edge m -> done high in cycle after edge m+2 (ACCUM, EVAL).
- Not-enrolled auth: start at edge k -> done high after edge k+1.
- Timeout: start at k -> done high after edge k+TIMEOUT+1.
- done high exactly one cycle; busy low in that same cycle.
- Reset mid-operation: immediate return to IDLE, puf_enable low, enrolled and golden cleared.

## Test plan
- Reset asserted mid-idle with prior results -> all outputs 0, busy 0, golden 0000.
- RESP_W=4, NUM_SAMPLES=3: enroll, PUF returns 1010, 1011, 0010 -> three puf_enable pulses each low ≥1 cycle between, golden=1010, enrolled=1, single done pulse.
- After enrollment, authenticate with 1011 -> hd=1, pass=1; authenticate with 0011 -> hd=2, pass=0; golden stays 1010.
- Authenticate after reset (enrolled=0) -> no puf_enable, done one cycle after start, not_enrolled_err=1, pass=0.
- TIMEOUT=20, enroll, PUF never asserts valid -> puf_enable high 20 cycles, done, timeout_err=1, golden/enrolled unchanged; valid on 20th cycle instead -> accepted, no timeout.
- Reset after 2nd enrollment sample, plus start pulses while busy -> extra starts ignored; reset returns IDLE, enrolled=0, puf_enable=0.
